// File: rtl/des_pkg.sv
// des_pkg: DES permutation tables, S-boxes, key shift schedules and helpers
package des_pkg;

    typedef logic [31:0] half_t;
    typedef logic [47:0] subkey_t;
    typedef logic [27:0] cd_t;
    typedef enum logic {IDLE, RUN} state_t;

    localparam int IP [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};

    localparam int E [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

    localparam int P [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};

    localparam int PC2 [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Each S-box is stored row-major: entry = row * 16 + column.
    localparam int SBOX [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    // Rotation applied to C/D just before each round; decrypt walks the encrypt schedule backwards.
    localparam int ENC_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int DEC_SHIFT [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Tables number bits from 1 at the MSB, so source bit n maps to vector index W-n.
    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        for (int i = 0; i < 64; i++) ip_perm[63 - i] = x[6'(64 - IP[i])];
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        for (int i = 0; i < 64; i++) fp_perm[63 - i] = x[6'(64 - FP[i])];
    endfunction

    function automatic subkey_t e_perm(input half_t x);
        for (int i = 0; i < 48; i++) e_perm[47 - i] = x[5'(32 - E[i])];
    endfunction

    function automatic half_t p_perm(input half_t x);
        for (int i = 0; i < 32; i++) p_perm[31 - i] = x[5'(32 - P[i])];
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        for (int i = 0; i < 56; i++) pc1_perm[55 - i] = x[6'(64 - PC1[i])];
    endfunction

    function automatic subkey_t pc2_perm(input logic [55:0] x);
        for (int i = 0; i < 48; i++) pc2_perm[47 - i] = x[6'(56 - PC2[i])];
    endfunction

    // Row comes from the outer two bits, column from the inner four.
    function automatic logic [3:0] sbox(input logic [2:0] n, input logic [5:0] b);
        return 4'(SBOX[n][{b[5], b[0], b[4:1]}]);
    endfunction

    function automatic cd_t rotl(input cd_t x, input logic [1:0] n);
        return n[1] ? {x[25:0], x[27:26]} : n[0] ? {x[26:0], x[27]} : x;
    endfunction

    function automatic cd_t rotr(input cd_t x, input logic [1:0] n);
        return n[1] ? {x[1:0], x[27:2]} : n[0] ? {x[0], x[27:1]} : x;
    endfunction

    // DES wants odd parity in every key byte; flag any byte with even parity.
    function automatic logic parity_err(input logic [63:0] k);
        parity_err = 1'b0;
        for (int i = 0; i < 8; i++) parity_err |= ~^k[8 * i +: 8];
    endfunction

endpackage

// File: rtl/des_round.sv
// des_round: one DES Feistel round (f-function plus XOR into the left half)
module des_round
    import des_pkg::*;
(
    input  half_t   l_i,
    input  half_t   r_i,
    input  subkey_t k_i,
    output half_t   l_o,
    output half_t   r_o
);

    subkey_t x;
    half_t   s;

    // Expand R, mix in the subkey and substitute through the eight S-boxes.
    always_comb begin
        x = e_perm(r_i) ^ k_i;
        s = '0;
        for (int i = 0; i < 8; i++) s[31 - 4 * i -: 4] = sbox(3'(i), x[47 - 6 * i -: 6]);
    end

    assign l_o = r_i;
    assign r_o = l_i ^ p_perm(s);

endmodule

// File: rtl/des_iterative_core.sv
// des_iterative_core: iterative single-DES engine, one round per enabled clock.
// Optional DES_KEY_PARITY_EN adds key_parity_err reporting even-parity key bytes.
module des_iterative_core
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [63:0] data_in,
    input  logic        data_en,
    input  logic [63:0] key_in,
    input  logic        mode_in,
    input  logic        key_en,
    output logic [63:0] data_out,
    output logic        des_busy,
    output logic        des_wr
`ifdef DES_KEY_PARITY_EN
    ,
    output logic        key_parity_err
`endif
);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [55:0] key_q, cd_q, cd_d;
    logic        mode_q, wr_q;
    half_t       l_q, r_q, l_d, r_d;
    logic [63:0] dout_q;
    logic [1:0]  sh;
    logic [63:0] ip_in;

    assign sh    = 2'(mode_q ? DEC_SHIFT[cnt_q] : ENC_SHIFT[cnt_q]);
    assign cd_d  = mode_q ? {rotr(cd_q[55:28], sh), rotr(cd_q[27:0], sh)}
                          : {rotl(cd_q[55:28], sh), rotl(cd_q[27:0], sh)};
    assign ip_in = ip_perm(data_in);

    des_round u_round (
        .l_i (l_q),
        .r_i (r_q),
        .k_i (pc2_perm(cd_d)),
        .l_o (l_d),
        .r_o (r_d)
    );

    // Control FSM: key load and block start when idle, one round per enabled cycle when running.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            cd_q    <= '0;
            mode_q  <= 1'b0;
            l_q     <= '0;
            r_q     <= '0;
            dout_q  <= '0;
            wr_q    <= 1'b0;
        end else if (clk_en) begin
            wr_q <= 1'b0;
            if (state_q == IDLE) begin
                if (key_en) begin
                    key_q  <= pc1_perm(key_in);
                    mode_q <= mode_in;
                end
                if (data_en) begin
                    l_q     <= ip_in[63:32];
                    r_q     <= ip_in[31:0];
                    cd_q    <= key_en ? pc1_perm(key_in) : key_q;
                    cnt_q   <= '0;
                    state_q <= RUN;
                end
            end else begin
                l_q   <= l_d;
                r_q   <= r_d;
                cd_q  <= cd_d;
                cnt_q <= cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    dout_q  <= fp_perm({r_d, l_d});
                    wr_q    <= 1'b1;
                    state_q <= IDLE;
                end
            end
        end
    end

`ifdef DES_KEY_PARITY_EN
    logic perr_q;

    // Parity status follows every accepted key load.
    always_ff @(posedge clk) begin
        if (rst) perr_q <= 1'b0;
        else if (clk_en && state_q == IDLE && key_en) perr_q <= parity_err(key_in);
    end

    assign key_parity_err = perr_q;
`endif

    assign data_out = dout_q;
    assign des_busy = (state_q == RUN);
    assign des_wr   = wr_q;

endmodule

// File: tb/tb_des_iterative_core.sv
// tb_des_iterative_core: directed-vector bench for the iterative DES core
module tb_des_iterative_core;

    logic        clk = 1'b0, rst = 1'b1, clk_en = 1'b1;
    logic        data_en = 1'b0, key_en = 1'b0, mode_in = 1'b0;
    logic [63:0] data_in = '0, key_in = '0;
    logic [63:0] data_out;
    logic        des_busy, des_wr;
`ifdef DES_KEY_PARITY_EN
    logic        key_parity_err;
`endif
    int          checks = 0, errors = 0, lat = 0, bsy = 0;
    logic [63:0] res1, res2;

    localparam logic [63:0] K1  = 64'ha1b2c3d4e5f61234;
    localparam logic [63:0] PT1 = 64'h85abcd1a98876543;
    localparam logic [63:0] CT1 = 64'h4bbd010363a955c0;
    localparam logic [63:0] PT2 = 64'h85abcd1b98876543;
    localparam logic [63:0] KK  = 64'h133457799bbcdff1;
    localparam logic [63:0] KP  = 64'h0123456789abcdef;
    localparam logic [63:0] KC  = 64'h85e813540f0ab405;

    des_iterative_core dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .data_in  (data_in),
        .data_en  (data_en),
        .key_in   (key_in),
        .mode_in  (mode_in),
        .key_en   (key_en),
        .data_out (data_out),
        .des_busy (des_busy),
        .des_wr   (des_wr)
`ifdef DES_KEY_PARITY_EN
        ,
        .key_parity_err (key_parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        tick();
        lat++;
        bsy += int'(des_busy);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_key(input logic [63:0] k, input logic m);
        key_en = 1'b1; key_in = k; mode_in = m;
        tick();
        key_en = 1'b0; key_in = '0;
    endtask

    task automatic start(input logic [63:0] d, input logic ken, input logic [63:0] k, input logic m);
        data_en = 1'b1; data_in = d; key_en = ken; key_in = k; mode_in = m;
        tick();
        data_en = 1'b0; key_en = 1'b0; key_in = '0;
        data_in = 64'(~d);
        lat = 0;
        bsy = int'(des_busy);
    endtask

    task automatic finish_wait(input int limit);
        while (!des_wr && lat < limit) step();
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        chk("reset_data_out", data_out, 64'd0);
        chk("reset_busy", 64'(des_busy), 64'd0);
        chk("reset_wr", 64'(des_wr), 64'd0);

        load_key(K1, 1'b0);
`ifdef DES_KEY_PARITY_EN
        chk("parity_err_set", 64'(key_parity_err), 64'd1);
`endif
        start(PT1, 1'b0, '0, 1'b0);
        finish_wait(64);
        chk("enc_latency", 64'(lat), 64'd16);
        chk("enc_busy_cycles", 64'(bsy), 64'd16);
        chk("enc_result", data_out, CT1);
        tick();
        chk("enc_wr_drop", 64'(des_wr), 64'd0);
        chk("enc_hold", data_out, CT1);

        load_key(K1, 1'b1);
        start(CT1, 1'b0, '0, 1'b0);
        finish_wait(64);
        chk("dec_result", data_out, PT1);

        start(PT1, 1'b1, K1, 1'b0);
        finish_wait(64);
        res1 = data_out;
        start(PT2, 1'b0, '0, 1'b0);
        finish_wait(64);
        chk("b2b_gap_after_first", 64'(lat + 1), 64'd17);
        res2 = data_out;
        checks++;
        assert (res2 !== res1) else begin
            errors++;
            $error("FAIL b2b_differs observed %h expected not %h", res2, res1);
        end
        start(res2, 1'b1, K1, 1'b1);
        finish_wait(64);
        chk("b2b_roundtrip", data_out, PT2);

        start(KP, 1'b1, KK, 1'b0);
        repeat (5) step();
        data_en = 1'b1; data_in = 64'hffffffffffffffff;
        step();
        data_en = 1'b0;
        finish_wait(64);
        chk("kat_latency", 64'(lat), 64'd16);
        chk("kat_result", data_out, KC);

        start(KP, 1'b0, '0, 1'b0);
        repeat (4) step();
        clk_en = 1'b0;
        repeat (5) step();
        chk("stall_busy", 64'(des_busy), 64'd1);
        clk_en = 1'b1;
        finish_wait(64);
        chk("stall_latency", 64'(lat), 64'd21);
        chk("stall_result", data_out, KC);
        clk_en = 1'b0;
        repeat (3) tick();
        chk("stall_wr_held", 64'(des_wr), 64'd1);
        clk_en = 1'b1;
        tick();
        chk("stall_wr_drop", 64'(des_wr), 64'd0);

`ifdef DES_KEY_PARITY_EN
        load_key(64'h0101010101010101, 1'b0);
        chk("parity_err_clear", 64'(key_parity_err), 64'd0);
`endif

        start(KP, 1'b1, KK, 1'b0);
        repeat (6) step();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 64'(des_busy), 64'd0);
        chk("abort_wr", 64'(des_wr), 64'd0);
        chk("abort_data_out", data_out, 64'd0);
        lat = 0;
        finish_wait(20);
        chk("abort_no_wr", 64'(des_wr), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1);
    end

endmodule
